// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer: runs the CNN stages in order (start pulse, wait for done),
// with a per-stage watchdog that latches a fault.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module layer_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 32,
  parameter int IDX_W          = (NUM_STAGES <= 1) ? 1 : $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage,
  output logic [CNT_W-1:0]      total_cycles
);

  localparam int WD_W = (TIMEOUT_CYCLES <= 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cur_stage_q, cur_stage_d;
  logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [IDX_W-1:0]      err_stage_q, err_stage_d;
  logic [CNT_W-1:0]      total_q, total_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;

  logic                  cur_done;
  logic                  run_state;

  // Select via one-hot mask so the index width never has to match the vector.
  assign cur_done  = |(stage_done & (NUM_STAGES'(1) << cur_stage_q));
  assign run_state = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_NEXT);

  always_comb begin
    state_d     = state_q;
    cur_stage_d = cur_stage_q;
    error_d     = error_q;
    err_stage_d = err_stage_q;
    wdog_d      = wdog_q;
    total_d     = total_q;

    if (run_state && (total_q != {CNT_W{1'b1}})) begin
      total_d = total_q + CNT_W'(1);
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_FAULT: begin
          if (go) begin
            state_d     = S_LAUNCH;
            cur_stage_d = '0;
            total_d     = '0;
            error_d     = 1'b0;
          end
        end
        S_LAUNCH: begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A done on the timeout edge still counts as success.
          if (cur_done) begin
            state_d = (cur_stage_q == LAST_IDX) ? S_FINISH : S_NEXT;
          end else if (wdog_q == WD_LAST) begin
            state_d     = S_FAULT;
            error_d     = 1'b1;
            err_stage_d = cur_stage_q;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
        S_NEXT: begin
          cur_stage_d = cur_stage_q + IDX_W'(1);
          state_d     = S_LAUNCH;
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they leave flops aligned with it.
    stage_start_d = (state_d == S_LAUNCH) ? (NUM_STAGES'(1) << cur_stage_d) : '0;
    busy_d        = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_NEXT);
    done_d        = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cur_stage_q   <= '0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_stage_q   <= '0;
      total_q       <= '0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      cur_stage_q   <= cur_stage_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_stage_q   <= err_stage_d;
      total_q       <= total_d;
      wdog_q        <= wdog_d;
    end
  end

  assign stage_start  = stage_start_q;
  assign cur_stage    = cur_stage_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_stage    = err_stage_q;
  assign total_cycles = total_q;

endmodule

`default_nettype wire

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level inference controller that runs the CNN stages (conv2d, relu, maxpool, dense, ...) strictly in order.
- For each stage it issues a one-cycle start pulse, then waits for that stage's done.
- A per-stage watchdog detects a hung stage and latches a fault.
- Sits between the host/UART control logic and the layer datapath blocks; reports busy, done, fault status and a total-run cycle count.

Parameters:
- NUM_STAGES, 4, number of sequenced stages; stage 0 = conv2d, indices run in execution order; must be ≥1.
- TIMEOUT_CYCLES, 65535, max WAIT cycles per stage before fault; must be ≥1.
- CNT_W, 32, width of total_cycles counter.
- IDX_W, (NUM_STAGES<=1)?1:$clog2(NUM_STAGES), stage index width (derived).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- go  in  1  run request, sampled in IDLE or FAULT only
- abort  in  1  synchronous abort, any state
- stage_start  out  NUM_STAGES  one-hot start pulse to stage i
- stage_done  in  NUM_STAGES  done from stage i (pulse or level)
- cur_stage  out  IDX_W  index of active or last stage
- busy  out  1  high in LAUNCH/WAIT/NEXT
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky fault flag
- err_stage  out  IDX_W  stage that timed out, valid while error=1
- total_cycles  out  CNT_W  cycles of last/current run

Behaviour:
- Reset (reset_n=0, async): state=IDLE; stage_start=0, cur_stage=0, busy=0, done=0, error=0, err_stage=0, total_cycles=0, watchdog=0. All outputs are registered.
- States: IDLE, LAUNCH, WAIT, NEXT, FINISH, FAULT.
- IDLE, go=1 at edge T:
  - next state LAUNCH, cur_stage=0, total_cycles=0, error=0.
  - In cycle T..T+1: stage_start[0]=1, busy=1.
- LAUNCH: exactly one cycle.
  - stage_start[cur_stage]=1; all other bits 0; watchdog cleared.
  - Next state WAIT.
  - stage_done is ignored in LAUNCH, so a stale level done from the previous run is not counted.
- WAIT: stage_start=0; watchdog increments each cycle.
  - stage_done[cur_stage]=1 sampled: if cur_stage==NUM_STAGES-1 go to FINISH, else go to NEXT.
  - Else, watchdog==TIMEOUT_CYCLES-1: go to FAULT, err_stage=cur_stage, error=1.
  - stage_done bits of other stages are ignored.
  - Done and timeout on the same edge: done wins.
- NEXT: one cycle.
  - cur_stage increments; next state LAUNCH.
  - Gap from done[i] sampled to stage_start[i+1] high = 2 cycles. This gives a level-done stage one cycle to drop done.
- FINISH: one cycle.
  - done=1, busy=0; next state IDLE; cur_stage holds the last index.
- FAULT: busy=0, error=1 held, stage_start=0.
  - go=1: restarts exactly as from IDLE and clears error.
  - abort=1: goes to IDLE; error stays set until the next go.
- total_cycles:
  - Increments every cycle in LAUNCH/WAIT/NEXT.
  - Frozen in IDLE/FINISH/FAULT; saturates at all-ones.
- abort=1 at any edge in LAUNCH/WAIT/NEXT: next state IDLE, stage_start=0, busy=0, no done pulse, total_cycles frozen.
- abort and go on the same edge: abort wins (stay/go IDLE).
- go while busy is ignored; no queuing.
- reset_n asserted mid-run: immediate return to reset values; no start pulse may be truncated into a glitch (outputs come from flops).

Test Plan (NUM_STAGES=3, TIMEOUT_CYCLES=20, stage models respond with done pulse N cycles after start):
- Nominal run, stages respond after 5/3/7 cycles; go pulse:
  - stage_start pulses 0→1→2, each exactly one cycle.
  - start[i+1] comes 2 cycles after done[i].
  - done pulses once; error=0; total_cycles = (1+5)+1+(1+3)+1+(1+7) = 20 (±fixed offset documented by implementer, checked consistently).
- Timeout at stage 1 (never responds):
  - WAIT lasts 20 cycles, then error=1, err_stage=1, busy=0, no done, stage 2 never started.
  - A following go reruns from stage 0 with error cleared.
- Level done: stage 0 holds done high until its next start:
  - The second run does not skip stage 0 (LAUNCH ignores done); full 3-stage sequence repeats.
- Abort during stage 2 WAIT:
  - Next cycle busy=0, no done, total_cycles frozen.
  - go while busy earlier in the run had no effect.
- Same-edge done and timeout: stage 0 done on cycle 20 of WAIT → proceeds to NEXT, error stays 0.
- Async reset: drop reset_n mid-WAIT between clock edges → all outputs 0 immediately; after release, go runs normally.
